// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_seq
//  Description : Sequential packed-BCD to binary converter (reverse double
//                dabble). Each SHIFT cycle shifts the working register right
//                by one bit. Any BCD nibble that is >= 8 after the shift then
//                has 3 subtracted. Fixed latency with a start/busy/done
//                handshake.
//  Ports       : clk      - system clock, rising edge
//                rst      - asynchronous active-high reset
//                start    - conversion request, sampled only in IDLE
//                bcd_in   - packed BCD, digit 0 in [3:0]
//                busy     - conversion in progress
//                done     - one-cycle pulse, bin_out valid and new
//                bin_out  - binary result, held until the next done
//                err      - (BCD2BIN_ERR_EN only) last result came from an
//                           input with a nibble > 9; bin_out reads all ones
//  Options     : define BCD2BIN_ERR_EN to add invalid-digit detection (err)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 4 * DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
`ifdef BCD2BIN_ERR_EN
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
`else
    output logic [BIN_W-1:0]      bin_out
`endif
);

    // c_BW : width of the BCD field and of the binary field in the shift register
    // c_SW : total width of the working shift register
    localparam int c_BW = 4 * DIGITS;
    localparam int c_SW = 8 * DIGITS;
    localparam int c_CW = $clog2(4 * DIGITS + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(4 * DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [c_SW-1:0]    r_sreg;
    logic [c_SW-1:0]    w_sreg_nx;
    logic [c_CW-1:0]    r_cnt;
    logic [c_CW-1:0]    w_cnt_nx;
    logic               r_busy;
    logic               w_busy_nx;
    logic               r_done;
    logic               w_done_nx;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_nx;

    logic [c_SW-1:0]    w_shift;
    logic [c_SW-1:0]    w_corr;
    logic [BIN_W-1:0]   w_res;
    logic               w_last;

    assign w_last  = (r_cnt == c_LAST);
    assign w_shift = r_sreg >> 1;

    // The binary half only ever receives bits; no correction applies there.
    assign w_corr[c_BW-1:0] = w_shift[c_BW-1:0];

    // One subtract-3 stage per BCD nibble, based on the post-shift value. A
    // nibble is >= 8 exactly when a 1 has just entered its MSB from the digit
    // above. That bit is worth 8 here but should be worth 10/2 = 5, so 3 is
    // taken off. The last shift leaves every nibble at zero, so it is skipped.
    for (genvar k = 0; k < DIGITS; k++) begin : g_nib
        localparam int c_LO = c_BW + 4 * k;
        assign w_corr[c_LO +: 4] = (w_shift[c_LO + 3] && !w_last)
                                   ? (w_shift[c_LO +: 4] - 4'd3)
                                   : w_shift[c_LO +: 4];
    end

    if (BIN_W > c_BW) begin : g_pad
        assign w_res = {{(BIN_W - c_BW){1'b0}}, r_sreg[c_BW-1:0]};
    end else begin : g_fit
        assign w_res = r_sreg[BIN_W-1:0];
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_sreg_nx  = r_sreg;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_bin_nx   = r_bin;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sreg_nx  = {bcd_in, {c_BW{1'b0}}};
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sreg_nx = w_corr;
                w_cnt_nx  = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_nx = S_FINISH;
                end
            end
            S_FINISH: begin
                w_bin_nx   = w_res;
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sreg  <= w_sreg_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_bin   <= w_bin_nx;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

`ifdef BCD2BIN_ERR_EN
    logic r_err_pend;
    logic r_err;
    logic w_bad;

    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pend <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_err_pend <= w_bad;
            end
            if (r_state == S_FINISH) begin
                r_err <= r_err_pend;
            end
        end
    end

    assign err     = r_err;
    assign bin_out = r_err ? {BIN_W{1'b1}} : r_bin;
`else
    assign bin_out = r_bin;
`endif

endmodule
`default_nettype wire

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter using reverse double dabble (shift right, then subtract 3 from any digit >= 8).
- Inverse of the score/display binary-to-BCD path; converts packed BCD (keypad entry, stored high-score digits) back to binary for arithmetic and compares.
- Start/busy/done handshake; one bit per clock; fixed latency.

Parameters:
- DIGITS, 3, number of packed BCD digits on bcd_in. Legal range 1..8.
- BIN_W, 4*DIGITS, width of bin_out. Always large enough because 10^DIGITS < 16^DIGITS. Unused MSBs are driven 0.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- bcd_in  input  4*DIGITS  packed BCD; digit 0 in [3:0]; sampled on the accepted start cycle
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; bin_out is valid and new
- bin_out  output  BIN_W  binary result; holds until the next done

Behaviour:
- Reset: asynchronous, active-high, one clock; reset is asynchronous and active-high.
  - While rst is high: state = IDLE, busy = 0, done = 0, bin_out = 0, internal shift register = 0, count = 0.
- State machine: IDLE -> SHIFT -> FINISH -> IDLE.
- IDLE:
  - start = 1 at a clock edge loads sreg = {bcd_in, BIN_W'b0} (width 8*DIGITS), count = 0, busy = 1, next state SHIFT.
  - start = 0: remain in IDLE.
- SHIFT, each cycle:
  - sreg = sreg >> 1. The BCD LSB moves into the binary MSB; a 0 fills at the top.
  - Then, for each of the DIGITS upper nibbles independently: if the nibble >= 8, subtract 3.
  - The correction uses the post-shift value within the same cycle and never takes more than one stage of logic per nibble.
  - count increments. After 4*DIGITS shifts, go to FINISH. The final shift applies no correction; it is harmless because the nibbles are 0.
- FINISH, one cycle:
  - bin_out = sreg lower BIN_W bits.
  - done = 1 for exactly this cycle; busy = 0 on the same edge; return to IDLE.
- Latency:
  - start accepted at edge N; done is high in the cycle following edge N + 4*DIGITS + 1.
  - DIGITS = 3: done asserts 13 edges after the start edge.
  - Next start is accepted the cycle done is high (back-to-back throughput = 4*DIGITS + 2 cycles).
- start while busy or during FINISH: ignored; no queuing; bcd_in changes are ignored.
- bcd_in is not required to be stable after the accepted start cycle.
- Invalid digits (nibble > 9): the result is defined as the plain arithmetic outcome of the algorithm; no error is raised unless the optional feature is compiled in.
- Reset mid-conversion: immediate abort to the reset values above. No done pulse is produced; bin_out = 0.
- bin_out never changes except at FINISH or reset.

Optional Feature:
- Macro: BCD2BIN_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - On an accepted start, err_pending is set if any bcd_in nibble > 9.
  - At FINISH, err is updated with err_pending and held until the next FINISH.
  - When err = 1, bin_out is forced to all ones.
  - Timing and handshake are unchanged.
- Undefined: no err port, no checking logic; behaviour exactly as in Behaviour.

Test Plan:
- Reset, then start with bcd_in = 12'h999 -> done 13 edges later, bin_out = 10'd999 (12'h3E7), busy high for exactly 13 cycles.
- bcd_in = 12'h000, then 12'h255 back-to-back (second start in the done cycle) -> bin_out = 0, then 255 (12'h0FF). Two done pulses 14 cycles apart.
- Start with 12'h107; pulse start again and change bcd_in to 12'h999 mid-conversion -> single done, bin_out = 107 (12'h06B), second start ignored.
- Start with 12'h500; assert rst at shift 5 for 1 cycle -> busy = 0, done never pulses, bin_out = 0. A fresh start with 12'h042 afterwards gives 42.
- BCD2BIN_ERR_EN defined, bcd_in = 12'h1A0 -> err = 1, bin_out = 12'hFFF. Next start with 12'h010 -> err = 0, bin_out = 10.
- DIGITS = 1 build, sweep bcd_in 0..9 -> bin_out equals the input each time; done latency is 5 edges.
